// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and round-robin pick helper for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_e;

    // widest requester vector the helper supports
    localparam int MAX_REQ = 8;

    // first set bit of valid scanning last+1, last+2, ... modulo n
    function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] valid, input logic [2:0] last, input int n);
        logic [2:0] win;
        logic       found;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (i <= n && !found && valid[(int'(last) + i) % n]) begin
                win   = 3'((int'(last) + i) % n);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker, lowest priority on the last winner
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_last,
    output logic [IDX_W-1:0]   winner,
    output logic               any_valid
);

    // pick the next requester after rr_last that has a beat waiting
    always_comb begin
        winner    = IDX_W'(rr_next(MAX_REQ'(valid), 3'(rr_last), NUM_REQ));
        any_valid = |valid;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-granular round-robin sharing of one FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BEATS = 16,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]       i_req_last,
    output logic [NUM_REQ-1:0]       o_req_ready,
    output logic                     o_fifo_wr_en,
    output logic [WIDTH-1:0]         o_fifo_wr_data,
    input  logic                     i_fifo_full,
    output logic [IDX_W-1:0]         o_grant_idx,
    output logic                     o_busy,
    output logic                     o_err_overlong
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    arb_state_e       state;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] rr_last;
    logic [CNT_W-1:0] beat_cnt;
    logic [IDX_W-1:0] winner;
    logic             any_valid;
    logic             locked;
    logic             accept;
    logic             pkt_end;
    logic             overlong;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .valid     (i_req_valid),
        .rr_last   (rr_last),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // owner's handshake and write path; everything is held off while in reset
    always_comb begin
        locked         = state == ARB_LOCK && !i_rst;
        accept         = locked && i_req_valid[grant_idx] && !i_fifo_full;
        overlong       = !i_req_last[grant_idx] && int'(beat_cnt) + 1 == MAX_BEATS;
        pkt_end        = i_req_last[grant_idx] || overlong;
        o_req_ready    = (locked && !i_fifo_full) ? NUM_REQ'(1) << grant_idx : '0;
        o_fifo_wr_en   = accept;
        o_fifo_wr_data = i_req_data[grant_idx*WIDTH +: WIDTH];
        o_busy         = state == ARB_LOCK;
        o_grant_idx    = grant_idx;
    end

    // arbitrate in idle, hold the lock until the last beat or the beat limit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= ARB_IDLE;
            grant_idx      <= '0;
            rr_last        <= IDX_W'(NUM_REQ - 1);
            beat_cnt       <= '0;
            o_err_overlong <= 1'b0;
        end else begin
            o_err_overlong <= 1'b0;
            if (state == ARB_IDLE) begin
                if (any_valid) begin
                    grant_idx <= winner;
                    state     <= ARB_LOCK;
                end
            end else if (accept) begin
                if (pkt_end) begin
                    state          <= ARB_IDLE;
                    rr_last        <= grant_idx;
                    beat_cnt       <= '0;
                    o_err_overlong <= overlong;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: random and directed packet traffic checked against a packet-level model
module tb_fifo_wr_arbiter;

    localparam int N     = 2;
    localparam int W     = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   last;
    logic [N-1:0]   ready;
    logic           wr_en;
    logic [W-1:0]   wr_data;
    logic           full;
    logic [0:0]     grant;
    logic           busy;
    logic           err;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BEATS(MB)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (valid),
        .i_req_data     (data),
        .i_req_last     (last),
        .o_req_ready    (ready),
        .o_fifo_wr_en   (wr_en),
        .o_fifo_wr_data (wr_data),
        .i_fifo_full    (full),
        .o_grant_idx    (grant),
        .o_busy         (busy),
        .o_err_overlong (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // pending beats per requester as {last, data}
    logic [8:0] pend[N][$];
    int         gap[N];
    int         rd_pct = 0;
    int         count  = 0;
    logic [7:0] wlog[$];
    int         errs_seen = 0;
    logic [7:0] e[$];
    bit         rnd = 0;

    // model of who owns the port, who won last and how many beats were taken
    int owner = -1;
    int prev  = N - 1;
    int nb    = 0;
    bit m_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkseq(input string name);
        chk({name, "_len"}, wlog.size(), e.size());
        foreach (e[i]) if (i < wlog.size()) chk(name, wlog[i], e[i]);
    endtask

    task automatic push(input int k, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) pend[k].push_back({i == n - 1, 8'(base + i)});
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            valid[k]      = pend[k].size() > 0 && gap[k] == 0;
            data[k*W +: W] = pend[k].size() > 0 ? pend[k][0][7:0] : 8'($urandom);
            last[k]       = pend[k].size() > 0 ? pend[k][0][8] : 1'($urandom);
        end
        full = count >= DEPTH;
    endtask

    // one cycle: drive, compare at negedge, advance model, FIFO and drivers
    task automatic step();
        logic [N-1:0] er;
        bit           ew;
        bit           rd;
        drive();
        @(negedge clk);
        er = (!rst && owner >= 0 && !full) ? N'(1) << owner : '0;
        ew = er != 0 && valid[owner];
        chk("ready", ready, er);
        chk("wr_en", wr_en, ew);
        chk("busy", busy, owner >= 0);
        chk("err_overlong", err, m_err);
        if (owner >= 0) chk("grant", grant, owner);
        if (ew) begin
            chk("wr_data", wr_data, data[owner*W +: W]);
            wlog.push_back(data[owner*W +: W]);
        end
        if (err) errs_seen++;
        m_err = 0;
        if (rst) begin
            owner = -1;
            prev  = N - 1;
            nb    = 0;
        end else if (owner < 0) begin
            for (int i = 1; i <= N; i++) if (owner < 0 && valid[(prev + i) % N]) owner = (prev + i) % N;
        end else if (ew) begin
            nb++;
            void'(pend[owner].pop_front());
            if (last[owner] || nb == MB) begin
                m_err = !last[owner];
                prev  = owner;
                owner = -1;
                nb    = 0;
            end
        end
        rd = count > 0 && $urandom_range(99) < rd_pct;
        count = count + int'(wr_en) - int'(rd);
        if (count > DEPTH) chk("fifo_overflow", count, DEPTH);
        for (int k = 0; k < N; k++) begin
            if (gap[k] > 0) gap[k]--;
            else if (rnd && $urandom_range(3) == 0) gap[k] = $urandom_range(1, 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input int lim);
        int t = 0;
        while (wlog.size() < n && t < lim) begin
            step();
            t++;
        end
        if (wlog.size() < n) chk("timeout_wlog", wlog.size(), n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < N; k++) gap[k] = 0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("reset_busy", busy, 0);
        chk("reset_ready", ready, 0);
        rst = 1'b0;

        // single packet, FIFO empty, no reads
        push(0, 2, 8'h11);
        repeat (5) step();
        e = {8'h11, 8'h12};
        chkseq("t1_order");
        chk("t1_fifo_level", count, 2);

        // simultaneous requests from reset; req0 queues a second packet behind req1
        count = 0;
        wlog.delete();
        do_reset();
        push(0, 2, 8'hA1);
        push(0, 1, 8'hA3);
        push(1, 1, 8'hB1);
        repeat (10) step();
        e = {8'hA1, 8'hA2, 8'hB1, 8'hA3};
        chkseq("t2_rotation");

        // six beats into a four-deep FIFO with no reads, then drain
        count = 0;
        wlog.delete();
        errs_seen = 0;
        push(0, 6, 8'h30);
        repeat (10) step();
        chk("t3_writes_while_full", wlog.size(), 4);
        chk("t3_wr_en_full", wr_en, 0);
        chk("t3_ready_full", ready, 0);
        chk("t3_busy_full", busy, 1);
        rd_pct = 100;
        repeat (12) step();
        e = {8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        chkseq("t3_resume");
        chk("t3_overlong_pulses", errs_seen, 1);

        // five beats from req1 with last on the fifth
        wlog.delete();
        errs_seen = 0;
        push(1, 5, 8'h50);
        repeat (12) step();
        e = {8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
        chkseq("t4_split");
        chk("t4_overlong_pulses", errs_seen, 1);

        // reset after the first beat of a three-beat packet
        wlog.delete();
        push(0, 3, 8'h70);
        wait_log(1, 10);
        rst = 1'b1;
        push(1, 1, 8'h80);
        step();
        step();
        chk("t5_busy_after_reset", busy, 0);
        rst = 1'b0;
        repeat (10) step();
        e = {8'h70, 8'h71, 8'h72, 8'h80};
        chkseq("t5_after_reset");

        // req0 stalls mid-packet while req1 waits
        wlog.delete();
        push(0, 3, 8'h90);
        wait_log(1, 10);
        gap[0] = 3;
        push(1, 1, 8'hA0);
        repeat (12) step();
        e = {8'h90, 8'h91, 8'h92, 8'hA0};
        chkseq("t6_bubbles");

        // randomized traffic with random reads, stalls and occasional resets
        rnd = 1;
        rd_pct = 60;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++)
                if (pend[k].size() == 0 && $urandom_range(3) == 0) push(k, $urandom_range(1, 6), 8'($urandom));
            if (rst) rst = 1'b0;
            else if ($urandom_range(399) == 0) rst = 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
